// File: rtl/cpu_pipe_pkg.sv
// rtl/cpu_pipe_pkg.sv - shared pipeline types, occupancy encodings and default widths
package cpu_pipe_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 4;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_TWO   = 2'd2;

  typedef struct packed {
    logic                  MemToReg;
    logic                  RegWrite;
    logic                  MemWrite;
    logic [ADDR_W_DEF-1:0] destAdd;
    logic [DATA_W_DEF-1:0] MemReadData;
    logic [DATA_W_DEF-1:0] alu_result;
  } wb_payload_t;

endpackage

// File: rtl/wb_stage_pipe_if.sv
// rtl/wb_stage_pipe_if.sv - M-to-W handshake bundle; wb_dataW present only with WB_RESULT_MUX_EN
interface wb_stage_pipe_if #(
  parameter int DATA_W = cpu_pipe_pkg::DATA_W_DEF,
  parameter int ADDR_W = cpu_pipe_pkg::ADDR_W_DEF
);
  logic              in_valid;
  logic              in_ready;
  logic              MemToRegM;
  logic              RegWriteM;
  logic              MemWriteM;
  logic [ADDR_W-1:0] destAddM;
  logic [DATA_W-1:0] MemReadDataM;
  logic [DATA_W-1:0] alu_resultM;
  logic              out_valid;
  logic              out_ready;
  logic              MemToRegW;
  logic              RegWriteW;
  logic              MemWriteW;
  logic [ADDR_W-1:0] destAddW;
  logic [DATA_W-1:0] MemReadDataW;
  logic [DATA_W-1:0] alu_resultW;
  logic [1:0]        occupancy;
`ifdef WB_RESULT_MUX_EN
  logic [DATA_W-1:0] wb_dataW;
`endif

  modport master (
    output in_valid, MemToRegM, RegWriteM, MemWriteM, destAddM, MemReadDataM, alu_resultM, out_ready,
    input  in_ready, out_valid, MemToRegW, RegWriteW, MemWriteW, destAddW, MemReadDataW, alu_resultW,
`ifdef WB_RESULT_MUX_EN
    input  wb_dataW,
`endif
    input  occupancy
  );

  modport slave (
    input  in_valid, MemToRegM, RegWriteM, MemWriteM, destAddM, MemReadDataM, alu_resultM, out_ready,
    output in_ready, out_valid, MemToRegW, RegWriteW, MemWriteW, destAddW, MemReadDataW, alu_resultW,
`ifdef WB_RESULT_MUX_EN
    output wb_dataW,
`endif
    output occupancy
  );

endinterface

// File: rtl/wb_stage_pipe_skid_buf2.sv
// rtl/wb_stage_pipe_skid_buf2.sv - generic 2-entry valid/ready skid buffer; all outputs come from flops
module skid_buf2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   occupancy
);
  import cpu_pipe_pkg::*;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t       state;
  logic [W-1:0] skidData;
  logic         inFire;
  logic         outFire;

  assign inFire  = in_valid & in_ready;
  assign outFire = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      occupancy <= OCC_EMPTY;
      out_data  <= '0;
      skidData  <= '0;
    end else if (flush) begin
      // data registers keep their contents; only the valid state is dropped
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      occupancy <= OCC_EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (inFire) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
            occupancy <= OCC_ONE;
            state     <= ONE;
          end
        end
        ONE: begin
          if (inFire && outFire) begin
            out_data <= in_data;
          end else if (outFire) begin
            out_valid <= 1'b0;
            occupancy <= OCC_EMPTY;
            state     <= EMPTY;
          end else if (inFire) begin
            skidData  <= in_data;
            in_ready  <= 1'b0;
            occupancy <= OCC_TWO;
            state     <= TWO;
          end
        end
        TWO: begin
          if (outFire) begin
            out_data  <= skidData;
            in_ready  <= 1'b1;
            occupancy <= OCC_ONE;
            state     <= ONE;
          end
        end
        default: begin
          state     <= EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          occupancy <= OCC_EMPTY;
        end
      endcase
    end
  end

endmodule

// File: rtl/wb_stage_pipe.sv
// rtl/wb_stage_pipe.sv - elastic MEM/WB register with flush and write gating
// WB_RESULT_MUX_EN adds a pre-selected registered writeback value wb_dataW.
module wb_stage_pipe #(
  parameter int DATA_W = cpu_pipe_pkg::DATA_W_DEF,
  parameter int ADDR_W = cpu_pipe_pkg::ADDR_W_DEF
) (
  input logic            clk,
  input logic            reset,
  input logic            flush,
  wb_stage_pipe_if.slave bus
);
  import cpu_pipe_pkg::*;

  typedef struct packed {
    logic              MemToReg;
    logic              RegWrite;
    logic              MemWrite;
    logic [ADDR_W-1:0] destAdd;
    logic [DATA_W-1:0] MemReadData;
    logic [DATA_W-1:0] alu_result;
`ifdef WB_RESULT_MUX_EN
    logic [DATA_W-1:0] wbData;
`endif
  } payload_t;

  localparam int PW = $bits(payload_t);

  payload_t        inPay;
  payload_t        outPay;
  logic [PW-1:0]   outVec;
  logic            outValid;

  always_comb begin
    inPay             = '0;
    inPay.MemToReg    = bus.MemToRegM;
    inPay.RegWrite    = bus.RegWriteM;
    inPay.MemWrite    = bus.MemWriteM;
    inPay.destAdd     = bus.destAddM;
    inPay.MemReadData = bus.MemReadDataM;
    inPay.alu_result  = bus.alu_resultM;
`ifdef WB_RESULT_MUX_EN
    // select at load time so the W side sees a plain register
    inPay.wbData      = bus.MemToRegM ? bus.MemReadDataM : bus.alu_resultM;
`endif
  end

  skid_buf2 #(.W(PW)) u_buf (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (inPay),
    .out_valid (outValid),
    .out_ready (bus.out_ready),
    .out_data  (outVec),
    .occupancy (bus.occupancy)
  );

  assign outPay           = payload_t'(outVec);
  assign bus.out_valid    = outValid;
  assign bus.MemToRegW    = outPay.MemToReg;
  // a stale entry left in the main register must never write state
  assign bus.RegWriteW    = outPay.RegWrite & outValid;
  assign bus.MemWriteW    = outPay.MemWrite & outValid;
  assign bus.destAddW     = outPay.destAdd;
  assign bus.MemReadDataW = outPay.MemReadData;
  assign bus.alu_resultW  = outPay.alu_result;
`ifdef WB_RESULT_MUX_EN
  assign bus.wb_dataW     = outPay.wbData;
`endif

endmodule

// File: doc/wb_stage_pipe.md
Name: wb_stage_pipe

Overview:
- Parametrised elastic pipeline register between the memory stage (M) and the writeback stage (W) of the 16-bit CPU.
- Generalises the fixed MEM/WB register in three ways: parametrised data/address widths; a valid/ready handshake backed by a 2-entry skid buffer, so the W side can stall without a combinational ready path into M; and a synchronous flush.
- Carries MemToReg, RegWrite and MemWrite control, dest register address, memory read data and ALU result.

Parameters:
- DATA_W, 16, width of MemReadData and alu_result paths.
- ADDR_W, 4, width of the destination register address.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous flush: drop all held entries.
- in_valid  in  1  M side presents a valid entry.
- in_ready  out  1  block can accept an entry; registered.
- MemToRegM  in  1  select memory data for writeback.
- RegWriteM  in  1  register-file write enable.
- MemWriteM  in  1  memory write flag, passed through.
- destAddM  in  ADDR_W  destination register.
- MemReadDataM  in  DATA_W  load data.
- alu_resultM  in  DATA_W  ALU result.
- out_valid  out  1  W side entry valid.
- out_ready  in  1  W side consumes the entry.
- MemToRegW, RegWriteW, MemWriteW  out  1 each  registered controls.
- destAddW  out  ADDR_W  registered dest address.
- MemReadDataW, alu_resultW  out  DATA_W  registered data.
- occupancy  out  2  entries held: 0, 1 or 2.

Behaviour:
- Storage: main register (drives the outputs) plus skid register, each with a valid bit.
- States:
  - EMPTY: occupancy 0.
  - ONE: main valid.
  - TWO: main and skid valid.
- Fire conditions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- in_ready = ~skid_valid, taken from a flop only. It is 1 in EMPTY and ONE, 0 in TWO.
- out_valid = main_valid.
- EMPTY:
  - in_fire → main loaded, ONE.
  - Latency from input to output is exactly 1 cycle.
- ONE:
  - in_fire & out_fire → main reloaded with the new entry, stay ONE.
  - out_fire only → EMPTY.
  - in_fire only → skid loaded, TWO. Main is unchanged.
- TWO:
  - in_fire is impossible because in_ready=0.
  - out_fire → main <= skid, skid cleared, ONE. in_ready returns to 1 on the next cycle.
- Ordering: entries leave strictly in arrival order. No entry is duplicated or dropped except by flush or reset.
- Flush:
  - Next state is EMPTY, both valid bits cleared.
  - Any in_fire in the same cycle is discarded.
  - An out_fire in the flush cycle counts as consumed.
  - Data registers are left unchanged.
- Reset:
  - Priority: reset > flush > normal operation.
  - Next edge forces EMPTY. All outputs become 0: out_valid, MemToRegW, RegWriteW, MemWriteW, destAddW, MemReadDataW, alu_resultW, occupancy. in_ready becomes 1.
  - Reset mid-operation discards held entries.
- Control gating: RegWriteW and MemWriteW are forced to 0 whenever out_valid=0, so a stale entry never writes the register file.
- When out_valid=1 and out_ready=0, all W outputs hold stable.
- occupancy is a registered count that matches the state.

Optional Feature:
- Macro: WB_RESULT_MUX_EN.
- Defined:
  - Adds output port wb_dataW [DATA_W], a registered writeback value: MemToReg ? MemReadData : alu_result.
  - The mux is computed at load time for both main and skid, so there is no mux on the W-side path.
  - Reset value is 0. It follows the same hold and flush rules as the other W outputs.
- Undefined: the port and its registers are absent; the W stage does the selection.

Decomposition:
- Shared package cpu_pipe_pkg holds:
  - wb_payload_t: packed struct {MemToReg, RegWrite, MemWrite, destAdd, MemReadData, alu_result}, widths taken from package constants.
  - OCC_EMPTY/ONE/TWO encodings.
  - Default width constants: 16 for data, 4 for address.
- One natural sub-module: skid_buf2, a generic 2-entry valid/ready buffer over a packed payload. wb_stage_pipe wraps it and adds the gating and the optional mux.

Test Plan:
- Reset mid-TWO: hold out_ready=0, push 2 entries, assert reset → next cycle out_valid=0, occupancy=0, in_ready=1, all W outputs 0.
- Streaming: out_ready=1, push alu_result 0x0001..0x0010 back-to-back → each appears 1 cycle later, in order, with no bubbles; occupancy stays 1.
- Backpressure: out_ready=0, push A=0x1234 then B=0xBEEF → in_ready=0 after B, occupancy=2, outputs hold A. Release out_ready → A, then B, on consecutive cycles; in_ready=1 one cycle after A leaves.
- Flush with simultaneous in_fire in state ONE → next cycle out_valid=0, RegWriteW=0; the discarded entry never appears.
- Gating: entry with RegWriteM=1, then drain → RegWriteW=0 whenever out_valid=0, including after flush.
- WB_RESULT_MUX_EN: MemToRegM=1, MemReadData=0xAAAA, alu=0x5555 → wb_dataW=0xAAAA; with MemToRegM=0 → 0x5555.
